ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter BURST_LIMIT, default 4: address-phase transfers one owner may issue before it must yield to a waiting requester.
REQ-002 Parameter DEFAULT_MASTER, default 0: master parked on the bus when nobody requests.
REQ-003 hclk  in  1  single clock; all state updates on its rising edge.
REQ-004 hreset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 hbusreq_0/hbusreq_1  in  1 each  bus request per master.
REQ-006 htrans_m  in  2 each; haddr_m  in  3 each; hwrite_m  in  1 each; hsize_m  in  3 each; hwdata_m  in  8 each  (m = 0, 1) per-master AHB address/data signals.
REQ-007 hready  in  1  transfer-done from slave (slave hready_out).
REQ-008 hresp  in  1  slave error flag.
REQ-009 hgrant  out  2  one-hot grant, bit m = master m.
REQ-010 hmaster  out  1  index of current address-phase owner.
REQ-011 hsel_x, htrans(2), haddr(3), hwrite(1), hsize(3), hwdata(8)  out  muxed slave-side bus.
REQ-012 hready_m  out  1  hready broadcast to both masters.

Function
REQ-013 Address-phase outputs (htrans, haddr, hwrite, hsize) SHALL be combinationally muxed from master hmaster.
REQ-014 hwdata SHALL be muxed from hmaster_d, a register loading hmaster on every hclk edge with hready=1 (one-cycle data-phase lag).
REQ-015 hsel_x SHALL be 1 when htrans[1]=1 (NONSEQ/SEQ) and 0 otherwise.
REQ-016 FSM states: PARK (no request, grant DEFAULT_MASTER, htrans forced to IDLE), OWN (grant holder driving), HANDOVER (grant moved, old owner's data phase pending).
REQ-017 Re-arbitration SHALL occur only at an edge with hready=1 and owner htrans != SEQ (2'b11); SEQ beats are never broken.
REQ-018 Arbitration: round-robin; on simultaneous requests the master not granted last wins; a lone requester wins.
REQ-019 The owner SHALL keep the grant while hbusreq is high, unless beat_cnt = BURST_LIMIT and the other master requests, in which case it loses grant at the next legal point (REQ-017).
REQ-020 beat_cnt SHALL increment on each hready=1 edge with owner htrans[1]=1, saturate at BURST_LIMIT, and clear to 0 on any grant change.
REQ-021 OWN->HANDOVER on grant change; HANDOVER->OWN on the next hready=1 edge; OWN->PARK when no request at a legal point; PARK->OWN on any request.
REQ-022 hresp=1 with hready=1 SHALL force htrans to IDLE for the following cycle and mark the owner for re-arbitration at the next legal point.
REQ-023 hready low SHALL freeze hgrant, hmaster, hmaster_d, beat_cnt and FSM state.
REQ-024 hready_m SHALL equal hready.
REQ-025 A grant change SHALL appear on hgrant/hmaster on the edge after the decision, never mid-cycle.

Reset
REQ-026 Asserting hreset_n low at any time SHALL immediately set state=PARK, hgrant=one-hot DEFAULT_MASTER, hmaster=hmaster_d=DEFAULT_MASTER, beat_cnt=0, last-granted=DEFAULT_MASTER.
REQ-027 During reset htrans SHALL be IDLE and hsel_x 0; an in-flight burst is abandoned without a completing beat.
REQ-028 First arbitration SHALL occur on the first hready=1 edge after hreset_n rises.

Structure
REQ-029 HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and the FSM state enum SHALL live in shared package ahb_pkg, reused by the slave-side blocks.
REQ-030 Round-robin selection SHALL be one sub-module, ahb_rr_select (requests, last-granted -> winner index); muxing, FSM and counters stay in ahb_arbiter.

Verification
REQ-031 Reset, no requests -> hgrant=2'b01, htrans=IDLE, hsel_x=0.
REQ-032 Both request continuously, each issuing NONSEQ beats, hready=1 -> grant alternates every 4 transfers (BURST_LIMIT=4); hwdata tracks hmaster_d with one-cycle lag.
REQ-033 Master 0 in a SEQ burst, master 1 requests, beat_cnt=4 -> grant stays with master 0 until it issues a non-SEQ htrans, then moves to master 1.
REQ-034 hready held low 3 cycles mid-transfer while master 1 requests -> hgrant, hmaster, beat_cnt unchanged until hready returns.
REQ-035 hresp=1 with hready=1 on master 1 beat -> htrans=IDLE next cycle; grant passes to master 0 if it requests.
REQ-036 hreset_n asserted mid-burst of master 1 -> outputs at REQ-026/027 values within the same cycle, no further beat reaches the slave.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings: HTRANS values and the arbiter state enum.
// Slave-side blocks import the same definitions.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_PARK     = 2'b00,
    ST_OWN      = 2'b01,
    ST_HANDOVER = 2'b10
  } arb_state_e;

  localparam int NUM_MASTERS = 2;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic idx);
    onehot = 2'b01 << idx;
  endfunction

endpackage

// File: rtl/ahb_rr_select.sv
// Two-master round-robin pick: the master not granted last wins a tie,
// a lone requester always wins.
module ahb_rr_select
  import ahb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic                   i_last,
  output logic                   o_winner,
  output logic                   o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = i_req[~i_last] ? ~i_last : i_last;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter with bus mux: round-robin grant, per-owner burst
// limit, SEQ beats never split, error-triggered re-arbitration.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int BURST_LIMIT    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic       hclk,
  input  logic       hreset_n,
  input  logic       hbusreq_0,
  input  logic       hbusreq_1,
  input  logic [1:0] htrans_0,
  input  logic [1:0] htrans_1,
  input  logic [2:0] haddr_0,
  input  logic [2:0] haddr_1,
  input  logic       hwrite_0,
  input  logic       hwrite_1,
  input  logic [2:0] hsize_0,
  input  logic [2:0] hsize_1,
  input  logic [7:0] hwdata_0,
  input  logic [7:0] hwdata_1,
  input  logic       hready,
  input  logic       hresp,
  output logic [1:0] hgrant,
  output logic       hmaster,
  output logic       hsel_x,
  output logic [1:0] htrans,
  output logic [2:0] haddr,
  output logic       hwrite,
  output logic [2:0] hsize,
  output logic [7:0] hwdata,
  output logic       hready_m
);

  localparam int            CW      = $clog2(BURST_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LIMIT);
  localparam logic          DEF_M   = 1'(DEFAULT_MASTER);

  arb_state_e    r_state, w_state_next;
  logic          r_hmaster, w_hmaster_next;
  logic          r_hmaster_d;
  logic          r_last, w_last_next;
  logic [CW-1:0] r_beat_cnt, w_cnt_next, w_cnt_inc;
  logic          r_err, w_err_next;
  logic          r_idle_force;

  logic [1:0]    w_req;
  logic [1:0]    w_owner_trans;
  logic [1:0]    w_htrans;
  logic          w_beat;
  logic          w_legal;
  logic          w_yield;
  logic          w_winner;
  logic          w_any_req;

  assign w_req         = {hbusreq_1, hbusreq_0};
  assign w_owner_trans = r_hmaster ? htrans_1 : htrans_0;
  assign w_htrans      = ((r_state == ST_PARK) || r_idle_force) ? HTRANS_IDLE : w_owner_trans;
  assign w_beat        = w_htrans[1];
  assign w_legal       = (w_htrans != HTRANS_SEQ);

  // Count includes the beat completing at this edge, so the owner issues
  // exactly BURST_LIMIT transfers before handing over.
  assign w_cnt_inc = (w_beat && (r_beat_cnt != CNT_MAX)) ? r_beat_cnt + CW'(1) : r_beat_cnt;
  assign w_yield   = !w_req[r_hmaster]
                   || ((w_cnt_inc == CNT_MAX) && w_req[~r_hmaster])
                   || r_err;

  ahb_rr_select u_rr (
    .i_req    (w_req),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_any_req)
  );

  always_comb begin
    w_state_next   = r_state;
    w_hmaster_next = r_hmaster;
    w_last_next    = r_last;
    w_cnt_next     = w_cnt_inc;
    w_err_next     = r_err;
    case (r_state)
      ST_PARK: begin
        if (w_any_req) begin
          w_state_next   = ST_OWN;
          w_hmaster_next = w_winner;
          w_err_next     = 1'b0;
        end
      end
      ST_OWN: begin
        if (w_legal) begin
          w_err_next = 1'b0;
          if (!w_any_req) begin
            w_state_next   = ST_PARK;
            w_hmaster_next = DEF_M;
          end else if (w_yield && (w_winner != r_hmaster)) begin
            w_state_next   = ST_HANDOVER;
            w_hmaster_next = w_winner;
          end
        end
      end
      ST_HANDOVER: w_state_next = ST_OWN;
      default: begin
        w_state_next   = ST_PARK;
        w_hmaster_next = DEF_M;
      end
    endcase
    if (w_hmaster_next != r_hmaster) w_last_next = w_hmaster_next;
    if ((w_hmaster_next != r_hmaster) || (w_state_next == ST_PARK)) w_cnt_next = '0;
    if (hresp) w_err_next = 1'b1;
  end

  // Every register only advances on hready edges; a stalled slave freezes arbitration.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state      <= ST_PARK;
      r_hmaster    <= DEF_M;
      r_hmaster_d  <= DEF_M;
      r_last       <= DEF_M;
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
      r_idle_force <= 1'b0;
    end else if (hready) begin
      r_state      <= w_state_next;
      r_hmaster    <= w_hmaster_next;
      r_hmaster_d  <= r_hmaster;
      r_last       <= w_last_next;
      r_beat_cnt   <= w_cnt_next;
      r_err        <= w_err_next;
      r_idle_force <= hresp;
    end
  end

  assign hgrant   = onehot(r_hmaster);
  assign hmaster  = r_hmaster;
  assign htrans   = w_htrans;
  assign hsel_x   = w_htrans[1];
  assign haddr    = r_hmaster ? haddr_1  : haddr_0;
  assign hwrite   = r_hmaster ? hwrite_1 : hwrite_0;
  assign hsize    = r_hmaster ? hsize_1  : hsize_0;
  assign hwdata   = r_hmaster_d ? hwdata_1 : hwdata_0;
  assign hready_m = hready;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Table-driven bench for ahb_arbiter: per-cycle vectors with expected owner,
// data-phase owner and slave htrans, checked through a scoreboard queue.
module tb_ahb_arbiter;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [6:0] AP0 = {3'd2, 1'b1, 3'd1};
  localparam logic [6:0] AP1 = {3'd5, 1'b0, 3'd2};
  localparam logic [7:0] D0  = 8'hA0;
  localparam logic [7:0] D1  = 8'hB1;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic       hbusreq_0, hbusreq_1;
  logic [1:0] htrans_0, htrans_1;
  logic [2:0] haddr_0, haddr_1;
  logic       hwrite_0, hwrite_1;
  logic [2:0] hsize_0, hsize_1;
  logic [7:0] hwdata_0, hwdata_1;
  logic       hready, hresp;
  logic [1:0] hgrant;
  logic       hmaster;
  logic       hsel_x;
  logic [1:0] htrans;
  logic [2:0] haddr;
  logic       hwrite;
  logic [2:0] hsize;
  logic [7:0] hwdata;
  logic       hready_m;

  always #5 hclk = ~hclk;

  ahb_arbiter #(.BURST_LIMIT(4), .DEFAULT_MASTER(0)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .hbusreq_0(hbusreq_0), .hbusreq_1(hbusreq_1),
    .htrans_0(htrans_0), .htrans_1(htrans_1),
    .haddr_0(haddr_0), .haddr_1(haddr_1),
    .hwrite_0(hwrite_0), .hwrite_1(hwrite_1),
    .hsize_0(hsize_0), .hsize_1(hsize_1),
    .hwdata_0(hwdata_0), .hwdata_1(hwdata_1),
    .hready(hready), .hresp(hresp),
    .hgrant(hgrant), .hmaster(hmaster), .hsel_x(hsel_x),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hready_m(hready_m)
  );

  typedef struct {
    int         grp;
    logic       req0, req1;
    logic [1:0] tr0, tr1;
    logic       rdy, resp;
    logic       m, md;
    logic [1:0] trans;
  } vec_t;

  typedef struct {
    logic       m, md;
    logic [1:0] trans;
    logic       rdy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input int g, input logic r0, input logic r1, input logic [1:0] t0,
                     input logic [1:0] t1, input logic rdy, input logic resp,
                     input logic m, input logic md, input logic [1:0] tr);
    vec_t v;
    v.grp = g; v.req0 = r0; v.req1 = r1; v.tr0 = t0; v.tr1 = t1;
    v.rdy = rdy; v.resp = resp; v.m = m; v.md = md; v.trans = tr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_outputs(input exp_t e, input string tag);
    logic [6:0] ap;
    ap = {haddr, hwrite, hsize};
    chk($sformatf("%s hgrant", tag),   int'(hgrant),   e.m ? 2 : 1);
    chk($sformatf("%s hmaster", tag),  int'(hmaster),  int'(e.m));
    chk($sformatf("%s htrans", tag),   int'(htrans),   int'(e.trans));
    chk($sformatf("%s hsel_x", tag),   int'(hsel_x),   int'(e.trans[1]));
    chk($sformatf("%s addrph", tag),   int'(ap),       int'(e.m ? AP1 : AP0));
    chk($sformatf("%s hwdata", tag),   int'(hwdata),   int'(e.md ? D1 : D0));
    chk($sformatf("%s hready_m", tag), int'(hready_m), int'(e.rdy));
    $display("%s: hgrant=%b hmaster=%0d htrans=%b hsel_x=%0d hwdata=%02h",
             tag, hgrant, hmaster, htrans, hsel_x, hwdata);
  endtask

  // Holds reset with requests active; the bus must stay parked and idle.
  task automatic do_reset();
    exp_t e;
    @(posedge hclk); #1;
    hreset_n = 1'b0; hbusreq_0 = 1'b1; hbusreq_1 = 1'b1;
    htrans_0 = NSQ; htrans_1 = NSQ; hready = 1'b1; hresp = 1'b0;
    repeat (2) @(negedge hclk);
    e = '{1'b0, 1'b0, IDL, 1'b1};
    check_outputs(e, "reset");
  endtask

  task automatic run(input string tag, input int g);
    int k;
    k = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].grp == g) begin
        exp_t e;
        @(posedge hclk); #1;
        hreset_n  = 1'b1;
        hbusreq_0 = tbl[i].req0; hbusreq_1 = tbl[i].req1;
        htrans_0  = tbl[i].tr0;  htrans_1  = tbl[i].tr1;
        hready    = tbl[i].rdy;  hresp     = tbl[i].resp;
        e.m = tbl[i].m; e.md = tbl[i].md; e.trans = tbl[i].trans; e.rdy = tbl[i].rdy;
        sb_q.push_back(e);
        @(negedge hclk);
        e = sb_q.pop_front();
        check_outputs(e, $sformatf("%s[%0d]", tag, k));
        k++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    hreset_n = 1'b0; hbusreq_0 = 1'b0; hbusreq_1 = 1'b0;
    htrans_0 = IDL; htrans_1 = IDL; hready = 1'b1; hresp = 1'b0;
    haddr_0 = 3'd2; hwrite_0 = 1'b1; hsize_0 = 3'd1; hwdata_0 = D0;
    haddr_1 = 3'd5; hwrite_1 = 1'b0; hsize_1 = 3'd2; hwdata_1 = D1;

    // grp 0: both request NONSEQ; 4 transfers per owner, hwdata one cycle behind
    add(0, 1,1, NSQ,NSQ, 1,0, 0,0, IDL);
    add(0, 1,1, NSQ,NSQ, 1,0, 1,0, NSQ);
    for (int i = 0; i < 3; i++) add(0, 1,1, NSQ,NSQ, 1,0, 1,1, NSQ);
    add(0, 1,1, NSQ,NSQ, 1,0, 0,1, NSQ);
    for (int i = 0; i < 3; i++) add(0, 1,1, NSQ,NSQ, 1,0, 0,0, NSQ);
    add(0, 1,1, NSQ,NSQ, 1,0, 1,0, NSQ);
    for (int i = 0; i < 3; i++) add(0, 1,1, NSQ,NSQ, 1,0, 1,1, NSQ);
    // grp 1: master 0 SEQ burst past the limit; grant moves only after a NONSEQ
    add(1, 1,0, NSQ,IDL, 1,0, 0,0, IDL);
    add(1, 1,1, NSQ,NSQ, 1,0, 0,0, NSQ);
    for (int i = 0; i < 5; i++) add(1, 1,1, SQ,NSQ, 1,0, 0,0, SQ);
    add(1, 1,1, NSQ,NSQ, 1,0, 0,0, NSQ);
    add(1, 1,1, IDL,NSQ, 1,0, 1,0, NSQ);
    add(1, 1,1, IDL,NSQ, 1,0, 1,1, NSQ);
    // grp 2: hready low for 3 cycles freezes the beat count and grant
    add(2, 1,0, NSQ,IDL, 1,0, 0,0, IDL);
    add(2, 1,1, NSQ,NSQ, 1,0, 0,0, NSQ);
    for (int i = 0; i < 3; i++) add(2, 1,1, NSQ,NSQ, 0,0, 0,0, NSQ);
    for (int i = 0; i < 3; i++) add(2, 1,1, NSQ,NSQ, 1,0, 0,0, NSQ);
    add(2, 1,1, IDL,NSQ, 1,0, 1,0, NSQ);
    add(2, 1,1, IDL,NSQ, 1,0, 1,1, NSQ);
    // grp 3: error on a master 1 beat forces IDLE, then grant passes to master 0
    add(3, 1,1, IDL,NSQ, 1,0, 0,0, IDL);
    add(3, 1,1, IDL,NSQ, 1,0, 1,0, NSQ);
    add(3, 1,1, IDL,NSQ, 1,1, 1,1, NSQ);
    add(3, 1,1, IDL,NSQ, 1,0, 1,1, IDL);
    add(3, 1,1, NSQ,NSQ, 1,0, 0,1, NSQ);
    add(3, 1,1, NSQ,NSQ, 1,0, 0,0, NSQ);
    // grp 4: lead-in to a master 1 burst that reset interrupts
    add(4, 0,1, IDL,NSQ, 1,0, 0,0, IDL);
    add(4, 0,1, IDL,NSQ, 1,0, 1,0, NSQ);
    add(4, 0,1, IDL,SQ,  1,0, 1,1, SQ);

    do_reset(); run("alt",   0);
    do_reset(); run("seq",   1);
    do_reset(); run("stall", 2);
    do_reset(); run("hresp", 3);
    do_reset(); run("rstmid", 4);

    // Mid-burst asynchronous reset: outputs must park within the same cycle.
    @(posedge hclk); #1;
    htrans_1 = SQ;
    @(negedge hclk);
    e = '{1'b1, 1'b1, SQ, 1'b1};
    check_outputs(e, "rstmid[3]");
    #2 hreset_n = 1'b0;
    #1;
    e = '{1'b0, 1'b0, IDL, 1'b1};
    check_outputs(e, "rstmid_async");
    @(posedge hclk); #1;
    check_outputs(e, "rstmid_held");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
